// File: rtl/smul4_acc.sv
// Sequential 4x4 shift-add multiplier with remainder preload: p = q*b + r.
// One partial product per RUN cycle, four cycles total, registered outputs.
module smul4_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] q,
    input  logic [3:0] b,
    input  logic [3:0] r,
    output logic [7:0] p,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] q_l;
    logic [3:0] b_l;
    logic [7:0] acc;
    logic [1:0] cnt;
    logic [7:0] addend;
    logic [7:0] acc_nxt;

    // acc starts at r, so the final sum can never exceed 240.
    always_comb begin
        addend  = 8'h00;
        if (q_l[cnt])
            addend = {4'b0000, b_l} << cnt;
        acc_nxt = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p     <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= 8'h00;
            cnt   <= 2'd0;
            q_l   <= 4'h0;
            b_l   <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_l   <= q;
                        b_l   <= b;
                        acc   <= {4'b0000, r};
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        p     <= acc_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smul4_acc.sv
// Self-checking bench for smul4_acc: vector table, hand-written sequences,
// random operands and an exhaustive divider-inverse sweep.
module tb_smul4_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] q;
    logic [3:0] b;
    logic [3:0] r;
    logic [7:0] p;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_p;

    always #5 clk = ~clk;

    smul4_acc dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .b     (b),
        .r     (r),
        .p     (p),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] b;
        logic [3:0] r;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy/done/p=%h expected %h", name, act, exp);
        end
    endtask

    // Start one operation in the current cycle C and follow it through C+6.
    // hold keeps start high and scrambles operands during the operation.
    task automatic run_op(input string name, input logic [3:0] qi,
                          input logic [3:0] bi, input logic [3:0] ri,
                          input logic [7:0] exp_p, input bit hold);
        start = 1'b1;
        q = qi;
        b = bi;
        r = ri;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k < 5)
                chk($sformatf("%s run k=%0d", name, k), {busy, done, p},
                    {1'b1, 1'b0, last_p});
            else
                chk($sformatf("%s done", name), {busy, done, p},
                    {1'b1, 1'b1, exp_p});
            start = hold;
            if (hold) begin
                q = 4'($urandom);
                b = 4'($urandom);
                r = 4'($urandom);
            end
        end
        step();
        last_p = exp_p;
        chk($sformatf("%s idle", name), {busy, done, p},
            {1'b0, 1'b0, last_p});
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{q: 4'd3,  b: 4'd4,  r: 4'd1,  p: 8'h0D};
        vecs[1] = '{q: 4'd15, b: 4'd15, r: 4'd15, p: 8'hF0};
        vecs[2] = '{q: 4'd0,  b: 4'd9,  r: 4'd7,  p: 8'h07};
        vecs[3] = '{q: 4'd5,  b: 4'd0,  r: 4'd2,  p: 8'h02};
        vecs[4] = '{q: 4'd1,  b: 4'd1,  r: 4'd0,  p: 8'h01};
        vecs[5] = '{q: 4'd8,  b: 4'd15, r: 4'd15, p: 8'h87};
        vecs[6] = '{q: 4'd10, b: 4'd6,  r: 4'd3,  p: 8'h3F};
        vecs[7] = '{q: 4'd0,  b: 4'd0,  r: 4'd0,  p: 8'h00};

        rst = 1'b1;
        start = 1'b1;
        q = 4'd7;
        b = 4'd7;
        r = 4'd7;
        step();
        step();
        chk("reset state", {busy, done, p}, 10'h000);
        rst = 1'b0;
        last_p = 8'h00;

        // First cycle out of reset with start still high is accepted.
        run_op("first after reset", 4'd2, 4'd3, 4'd1, 8'd7, 1'b0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].b,
                   vecs[i].r, vecs[i].p, 1'b0);

        // Idle with start low holds p.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle hold", {busy, done, p}, {2'b00, last_p});
        end

        // start held high, operands scrambled: back-to-back with one idle gap.
        run_op("hold op1", 4'd3, 4'd4, 4'd1, 8'h0D, 1'b1);
        run_op("hold op2", 4'd9, 4'd7, 4'd5, 8'd68, 1'b0);

        // Reset in cycle C+2 aborts the operation.
        start = 1'b1;
        q = 4'd15;
        b = 4'd15;
        r = 4'd15;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_p = 8'h00;
        chk("abort C+3", {busy, done, p}, 10'h000);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("abort no done", {busy, done, p}, 10'h000);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0] rq, rb, rr;
            rq = 4'($urandom);
            rb = 4'($urandom);
            rr = 4'($urandom);
            run_op($sformatf("rand%0d", i), rq, rb, rr,
                   8'(int'(rq) * int'(rb) + int'(rr)), i[0]);
            if (i[1])
                step();
        end

        // Dividend reconstruction: feed the divider's (a/b, a%b).
        for (int a = 0; a < 16; a++)
            for (int d = 1; d < 16; d++)
                run_op($sformatf("sweep a=%0d b=%0d", a, d), 4'(a / d),
                       4'(d), 4'(a % d), 8'(a), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smul4_acc.md
SMUL4_ACC -- requirements
Module: smul4_acc

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have reset `rst`, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have `start`, input, 1 bit: request to begin one operation; sampled only in IDLE.
REQ-004 SHALL have `q`, input, 4 bits: quotient operand, unsigned.
REQ-005 SHALL have `b`, input, 4 bits: divisor operand, unsigned.
REQ-006 SHALL have `r`, input, 4 bits: remainder operand, unsigned.
REQ-007 SHALL have `p`, output, 8 bits: registered result p = q*b + r, unsigned.
REQ-008 SHALL have `busy`, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have `done`, output, 1 bit: one-cycle pulse; `p` is valid and new in that cycle.

Function
REQ-010 SHALL compute the dividend reconstruction p = q*b + r, the inverse of the team's 4-bit parallel divider; for any a and b != 0 with q,r from that divider, p SHALL equal {4'b0, a}.
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE with start=1, SHALL latch q, b, r into internal registers, set acc = {4'b0, r}, set the 2-bit iteration counter to 0, and go to RUN.
REQ-013 In IDLE with start=0, SHALL remain in IDLE with p held.
REQ-014 In RUN, each cycle SHALL add (latched b << cnt), zero-extended to 8 bits, to acc when latched q[cnt]=1, then increment cnt.
REQ-015 In RUN with cnt=3, SHALL perform the final add, load p with the final acc value, and go to DONE.
REQ-016 In DONE, SHALL assert done=1 for exactly one cycle and go to IDLE.
REQ-017 Latency: if start is sampled in cycle C, RUN SHALL occupy cycles C+1..C+4, done SHALL be high in cycle C+5, and IDLE SHALL be reached in cycle C+6.
REQ-018 busy SHALL be high in cycles C+1..C+5 and low in IDLE.
REQ-019 start SHALL be ignored while in RUN or DONE; latched operands SHALL NOT change mid-operation even if q, b or r inputs change.
REQ-020 p SHALL hold its previous result throughout RUN and SHALL change only on the RUN->DONE transition.
REQ-021 acc SHALL be 8 bits with no overflow possible (max 15*15+15=240); no saturation logic SHALL be required.
REQ-022 b=0 SHALL be legal and yield p = r; q=0 SHALL yield p = r.
REQ-023 start asserted in the first IDLE cycle after DONE SHALL begin a new operation (back-to-back gap of one IDLE cycle).

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, p=8'h00, busy=0, done=0, acc=0, cnt=0, with priority over start and any in-progress operation.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; p SHALL read 8'h00 afterwards.
REQ-026 The first start after reset release SHALL be accepted if sampled in a cycle with rst=0.

Verification
REQ-027 q=3, b=4, r=1, start pulsed in cycle C -> busy high C+1..C+5, done=1 only in C+5, p=8'h0D from C+5 on.
REQ-028 q=15, b=15, r=15 -> p=8'hF0 (240) with done in C+5.
REQ-029 q=0, b=9, r=7 and q=5, b=0, r=2 -> p=8'h07 and p=8'h02 respectively.
REQ-030 start held high continuously with operand inputs changing every cycle -> operands from cycle C used; second operation starts in C+6, done in C+11; no start accepted in C+1..C+5.
REQ-031 rst=1 in cycle C+2 of an operation -> cycle C+3 shows busy=0, done=0, p=8'h00; no done pulse follows.
REQ-032 Exhaustive sweep of a=0..15, b=1..15 through the divider's (q,r) -> every p equals a; compare against a reference model.
